conv_pingpong_scheduler: RTL and testbench

Sequences the ping-pong image buffers that feed the 3x3 FP16 convolution datapath. The write side accepts one full image row (IMAGE_SIZE pixels) per cycle into the free bank and marks the bank full after IMAGE_SIZE rows. The read side then scans every valid KERNEL_SIZE x KERNEL_SIZE window origin of the full bank in raster order, with a valid/ready handshake to the window/MAC stage. It frees the bank and swaps to the other bank when the scan completes. The block sits between the input row interface and the line-buffer/convolution core, and replaces ad-hoc ping_pong_enable/ready sequencing.

---
 rtl/conv_pingpong_scheduler.sv | 117 +++++++++++
 tb/tb_conv_pingpong_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pingpong_scheduler.sv
// Ping-pong bank scheduler: fills one image bank row-by-row while the other
// bank is scanned window-origin by window-origin for the 3x3 convolution core.
module conv_pingpong_scheduler #(
  parameter int IMAGE_SIZE  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [ADDR_SIZE-1:0] wr_row,
  output logic [1:0]           bank_full,
  output logic                 rd_bank,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [ADDR_SIZE-1:0] win_row,
  output logic [ADDR_SIZE-1:0] win_col,
  output logic                 win_last,
  output logic                 rd_en,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt
);

  localparam logic [ADDR_SIZE-1:0] LIM      = ADDR_SIZE'(IMAGE_SIZE - KERNEL_SIZE);
  localparam logic [ADDR_SIZE-1:0] ROW_LAST = ADDR_SIZE'(IMAGE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] win_row_nxt, win_col_nxt;
  logic                 row_last;
  logic [1:0]           set_mask, clr_mask;

  // Writes are suppressed during reset so a held in_valid cannot strobe the buffer.
  assign in_ready   = ~bank_full[wr_bank];
  assign wr_en      = in_valid & in_ready & ~rst;
  assign win_valid  = (state == SCAN);
  assign frame_done = (state == DONE);
  assign win_last   = win_valid & (win_row == LIM) & (win_col == LIM);
  assign rd_en      = win_valid & win_ready;
  assign row_last   = (wr_row == ROW_LAST);

  // Set and clear always target different banks, so both can apply on one edge.
  assign set_mask = (wr_en & row_last) ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = frame_done ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_row    <= '0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      if (wr_en) begin
        if (row_last) begin
          wr_bank <= ~wr_bank;
          wr_row  <= '0;
        end else begin
          wr_row  <= wr_row + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    win_row_nxt = win_row;
    win_col_nxt = win_col;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          state_nxt   = SCAN;
          win_row_nxt = '0;
          win_col_nxt = '0;
        end
      end
      SCAN: begin
        if (win_ready) begin
          if (win_last) begin
            state_nxt   = DONE;
            win_row_nxt = '0;
            win_col_nxt = '0;
          end else if (win_col < LIM) begin
            win_col_nxt = win_col + 1'b1;
          end else begin
            win_col_nxt = '0;
            win_row_nxt = win_row + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win_row   <= '0;
      win_col   <= '0;
      rd_bank   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      win_row <= win_row_nxt;
      win_col <= win_col_nxt;
      if (frame_done) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_pingpong_scheduler.sv
// Directed bench for conv_pingpong_scheduler: default 16x16 instance plus an 8x8 variant.
module tb_conv_pingpong_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, win_ready;
  logic       in_ready, wr_en, wr_bank, rd_bank, win_valid, win_last, rd_en, frame_done;
  logic [3:0] wr_row, win_row, win_col;
  logic [1:0] bank_full;
  logic [7:0] frame_cnt;

  logic       in_valid_s, win_ready_s;
  logic       in_ready_s, wr_en_s, wr_bank_s, rd_bank_s, win_valid_s, win_last_s, rd_en_s, frame_done_s;
  logic [2:0] wr_row_s, win_row_s, win_col_s;
  logic [1:0] bank_full_s;
  logic [7:0] frame_cnt_s;

  int asserts = 0;
  int fails   = 0;

  conv_pingpong_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_row(wr_row), .bank_full(bank_full), .rd_bank(rd_bank),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .win_last(win_last), .rd_en(rd_en), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  conv_pingpong_scheduler #(.IMAGE_SIZE(8), .KERNEL_SIZE(3), .ADDR_SIZE(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .wr_en(wr_en_s),
    .wr_bank(wr_bank_s), .wr_row(wr_row_s), .bank_full(bank_full_s), .rd_bank(rd_bank_s),
    .win_valid(win_valid_s), .win_ready(win_ready_s), .win_row(win_row_s), .win_col(win_col_s),
    .win_last(win_last_s), .rd_en(rd_en_s), .frame_done(frame_done_s), .frame_cnt(frame_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-speed scan of the default instance, checking every origin in raster order.
  task automatic scan_main(input int side, input int cnt_exp);
    int w = 0;
    win_ready = 1'b1;
    while (!win_valid && w < 20) begin tick(); w++; end
    chk("scan_start", 32'(w < 20), 1);
    for (int i = 0; i < side * side; i++) begin
      #1;
      chk("scan_row", win_row, i / side);
      chk("scan_col", win_col, i % side);
      chk("scan_last", win_last, 32'(i == side * side - 1));
      chk("scan_rd_en", rd_en, 1);
      tick();
    end
    #1;
    chk("done_pulse", frame_done, 1);
    chk("done_no_valid", win_valid, 0);
    tick();
    chk("done_single", frame_done, 0);
    chk("frame_cnt", frame_cnt, cnt_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, scyc, cyc, sent, dones, stall;
    logic prev_ready, prev_done;
    int ord [3];
    ord = '{0, 1, 0};

    // Reset held for two cycles with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; win_ready = 1'b0; in_valid_s = 1'b0; win_ready_s = 1'b0;
    tick(); tick();
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_wr_row", wr_row, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    // Single frame, back-to-back rows
    rst = 1'b0; in_valid = 1'b1; win_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      #1;
      chk("f0_wr_en", wr_en, 1);
      chk("f0_wr_row", wr_row, r);
      chk("f0_wr_bank", wr_bank, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("f0_bank_full", bank_full, 2'b01);
    chk("f0_wr_bank_swap", wr_bank, 1);
    chk("f0_wr_row_clr", wr_row, 0);
    chk("f0_not_yet_valid", win_valid, 0);
    tick();
    chk("f0_valid_rise", win_valid, 1);
    scan_main(14, 1);
    chk("f0_bank_free", bank_full, 0);
    chk("f0_rd_bank", rd_bank, 1);
    chk("f0_in_ready", in_ready, 1);

    // Backpressure: win_ready toggles starting with a stall cycle
    in_valid = 1'b1; win_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      #1;
      chk("bp_wr_bank", wr_bank, 1);
      chk("bp_wr_row", wr_row, r);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("bp_valid", win_valid, 1);
    acc = 0; scyc = 0; cyc = 0;
    while (win_valid && cyc < 1000) begin
      win_ready = (cyc % 2 == 1);
      #1;
      chk("bp_row", win_row, acc / 14);
      chk("bp_col", win_col, acc % 14);
      if (rd_en) acc++;
      scyc++;
      tick();
      cyc++;
    end
    chk("bp_accepts", acc, 196);
    chk("bp_scan_cycles", scyc, 392);
    chk("bp_done", frame_done, 1);
    win_ready = 1'b0;
    tick();
    chk("bp_frame_cnt", frame_cnt, 2);
    chk("bp_rd_bank", rd_bank, 0);
    chk("bp_bank_free", bank_full, 0);

    // Fresh start, then 48 rows offered continuously so both banks fill
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst2_frame_cnt", frame_cnt, 0);
    win_ready = 1'b1;
    sent = 0; dones = 0; stall = 0; cyc = 0; prev_ready = 1'b1; prev_done = 1'b0;
    while (dones < 3 && cyc < 3000) begin
      in_valid = (sent < 48);
      #1;
      if (in_valid && !in_ready) begin
        stall++;
        chk("both_full", bank_full, 2'b11);
      end
      if (in_valid && in_ready && !prev_ready) begin
        chk("resume_after_done", prev_done, 1);
        chk("resume_bank", wr_bank, 0);
        chk("resume_rows", sent, 32);
      end
      if (frame_done) begin
        chk("rd_order", rd_bank, ord[dones]);
        dones++;
      end
      if (wr_en) sent++;
      prev_ready = in_ready;
      prev_done  = frame_done;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("bb_dones", dones, 3);
    chk("bb_rows", sent, 48);
    chk("bb_stall_cycles", stall, 182);
    chk("bb_frame_cnt", frame_cnt, 3);
    chk("bb_bank_free", bank_full, 0);

    // Reset during window 50 with a partial row burst in the other bank
    acc = 0; cyc = 0;
    while (!(win_valid && acc == 50) && cyc < 500) begin
      in_valid = (cyc < 21);
      #1;
      if (rd_en) acc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    chk("mid_win_row", win_row, 3);
    chk("mid_win_col", win_col, 8);
    chk("mid_wr_row", wr_row, 5);
    chk("mid_bank_full", bank_full, 2'b10);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    chk("mr_win_valid", win_valid, 0);
    chk("mr_bank_full", bank_full, 0);
    chk("mr_wr_row", wr_row, 0);
    chk("mr_wr_bank", wr_bank, 0);
    chk("mr_rd_bank", rd_bank, 0);
    chk("mr_frame_cnt", frame_cnt, 0);
    chk("mr_win_col", win_col, 0);
    rst = 1'b0;
    for (int r = 0; r < 16; r++) tick();
    in_valid = 1'b0;
    chk("mr_refill", bank_full, 2'b01);
    scan_main(14, 1);

    // 8x8 variant: 36 windows, last at (5,5)
    in_valid_s = 1'b1;
    for (int r = 0; r < 8; r++) begin
      #1;
      chk("s_wr_row", wr_row_s, r);
      tick();
    end
    in_valid_s = 1'b0;
    #1;
    chk("s_bank_full", bank_full_s, 2'b01);
    tick();
    win_ready_s = 1'b1;
    for (int i = 0; i < 36; i++) begin
      #1;
      chk("s_valid", win_valid_s, 1);
      chk("s_row", win_row_s, i / 6);
      chk("s_col", win_col_s, i % 6);
      chk("s_last", win_last_s, 32'(i == 35));
      tick();
    end
    #1;
    chk("s_done", frame_done_s, 1);
    tick();
    chk("s_frame_cnt", frame_cnt_s, 1);
    chk("s_bank_free", bank_full_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
